// File: rtl/fphub_align_if.sv
// Handshake and data bundle for the HUB floating-point alignment stage.
// The master drives operands and out_ready; the slave returns the aligned pair.
interface fphub_align_if #(
   parameter int M = 24,
   parameter int E = 8
);
   logic [E+M:0] x;
   logic [E+M:0] y;
   logic [E:0]   diff;
   logic         x_greater_than_y;
   logic         in_valid;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready;
   logic         s_big;
   logic         s_small;
   logic [E-1:0] e_big;
   logic [M:0]   m_big;
   logic [M:0]   m_small;
   logic         eff_sub;

   modport master (
      output x, y, diff, x_greater_than_y, in_valid, out_ready,
      input  in_ready, out_valid, s_big, s_small, e_big, m_big, m_small, eff_sub
   );

   modport slave (
      input  x, y, diff, x_greater_than_y, in_valid, out_ready,
      output in_ready, out_valid, s_big, s_small, e_big, m_big, m_small, eff_sub
   );
endinterface

// File: rtl/fphub_align_stage.sv
// Two-stage HUB operand alignment: swap by exponent, then right-shift the smaller
// mantissa by the saturated exponent difference, truncating without a sticky bit.
module fphub_align_stage #(
   parameter int M = 24,
   parameter int E = 8
) (
   input logic           clk,
   input logic           rst,
   fphub_align_if.slave  port_io
);
   localparam int SHW = $clog2(M + 2);

   function automatic logic [M:0] hub_ext(input logic [E-1:0] ex, input logic [M-1:0] man);
      logic [M:0] r;
      if (ex == {E{1'b0}}) begin
         r = {(M+1){1'b0}};
      end else begin
         r = {man, 1'b1};
      end
      return r;
   endfunction

   logic           en_s;
   logic           load1_s;
   logic           load2_s;
   logic [E:0]     abs_diff_s;

   logic           s_big1_d,   s_big1_q;
   logic           s_small1_d, s_small1_q;
   logic [E-1:0]   e_big1_d,   e_big1_q;
   logic [M:0]     m_big1_d,   m_big1_q;
   logic [M:0]     m_small1_d, m_small1_q;
   logic [SHW-1:0] sh1_d,      sh1_q;
   logic           v1_q;

   logic           out_valid_q;
   logic           s_big_q, s_small_q, eff_sub_q;
   logic [E-1:0]   e_big_q;
   logic [M:0]     m_big_q, m_small_q;
   logic [M:0]     m_small_d;

   assign en_s    = !out_valid_q || port_io.out_ready;
   assign load1_s = en_s && port_io.in_valid;
   assign load2_s = en_s && v1_q;

   // Stage-1 next state: operand swap and saturated |diff|; the E+1-bit unsigned
   // magnitude holds 2^E, so the most negative diff cannot overflow.
   always_comb begin
      abs_diff_s = port_io.diff;
      s_big1_d   = 1'b0;
      s_small1_d = 1'b0;
      e_big1_d   = {E{1'b0}};
      m_big1_d   = {(M+1){1'b0}};
      m_small1_d = {(M+1){1'b0}};
      sh1_d      = {SHW{1'b0}};
      if (port_io.diff[E]) begin
         abs_diff_s = ~port_io.diff + {{E{1'b0}}, 1'b1};
      end else begin
         abs_diff_s = port_io.diff;
      end
      if (32'(abs_diff_s) >= 32'(M + 1)) begin
         sh1_d = SHW'(M + 1);
      end else begin
         sh1_d = SHW'(abs_diff_s);
      end
      if (port_io.x_greater_than_y) begin
         s_big1_d   = port_io.x[E+M];
         s_small1_d = port_io.y[E+M];
         e_big1_d   = port_io.x[E+M-1:M];
         m_big1_d   = hub_ext(port_io.x[E+M-1:M], port_io.x[M-1:0]);
         m_small1_d = hub_ext(port_io.y[E+M-1:M], port_io.y[M-1:0]);
      end else begin
         s_big1_d   = port_io.y[E+M];
         s_small1_d = port_io.x[E+M];
         e_big1_d   = port_io.y[E+M-1:M];
         m_big1_d   = hub_ext(port_io.y[E+M-1:M], port_io.y[M-1:0]);
         m_small1_d = hub_ext(port_io.x[E+M-1:M], port_io.x[M-1:0]);
      end
   end

   assign m_small_d = m_small1_q >> sh1_q;

   // Stage 1 register; data loads only for valid inputs so bubbles never leak data.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q       <= 1'b0;
         s_big1_q   <= 1'b0;
         s_small1_q <= 1'b0;
         e_big1_q   <= {E{1'b0}};
         m_big1_q   <= {(M+1){1'b0}};
         m_small1_q <= {(M+1){1'b0}};
         sh1_q      <= {SHW{1'b0}};
      end else if (en_s) begin
         v1_q <= port_io.in_valid;
         if (load1_s) begin
            s_big1_q   <= s_big1_d;
            s_small1_q <= s_small1_d;
            e_big1_q   <= e_big1_d;
            m_big1_q   <= m_big1_d;
            m_small1_q <= m_small1_d;
            sh1_q      <= sh1_d;
         end
      end
   end

   // Stage 2 register: shifted small mantissa and the registered output bundle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         s_big_q     <= 1'b0;
         s_small_q   <= 1'b0;
         eff_sub_q   <= 1'b0;
         e_big_q     <= {E{1'b0}};
         m_big_q     <= {(M+1){1'b0}};
         m_small_q   <= {(M+1){1'b0}};
      end else if (en_s) begin
         out_valid_q <= v1_q;
         if (load2_s) begin
            s_big_q   <= s_big1_q;
            s_small_q <= s_small1_q;
            eff_sub_q <= s_big1_q ^ s_small1_q;
            e_big_q   <= e_big1_q;
            m_big_q   <= m_big1_q;
            m_small_q <= m_small_d;
         end
      end
   end

   assign port_io.in_ready  = en_s;
   assign port_io.out_valid = out_valid_q;
   assign port_io.s_big     = s_big_q;
   assign port_io.s_small   = s_small_q;
   assign port_io.eff_sub   = eff_sub_q;
   assign port_io.e_big     = e_big_q;
   assign port_io.m_big     = m_big_q;
   assign port_io.m_small   = m_small_q;
endmodule
